// File: rtl/cache_mem_arbiter.sv
// Cache-side memory arbiter: shares one RAM port between an instruction read
// port and a data read/write port. Data wins arbitration except when the
// instruction side has been passed over STARVE_LIMIT times in a row.
module cache_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  // instruction port
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // data port
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM port
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready
);

  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] DSERV = 2'b01;
  localparam logic [1:0] ISERV = 2'b10;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     store_q, store_d;
  logic            wr_q, wr_d;

  logic d_req;
  logic starved;
  logic d_active;
  logic i_active;

  assign d_req    = dREN | dWEN;
  assign starved  = iREN && (starve_cnt_q == Limit);
  // A serve state only drives the RAM while its requester still asks for it.
  assign d_active = (state_q == DSERV) && d_req;
  assign i_active = (state_q == ISERV) && iREN;

  // Arbitration, request latching and starvation bookkeeping.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    store_d      = store_q;
    wr_d         = wr_q;
    case (state_q)
      IDLE: begin
        if (d_req && !starved) begin
          state_d = DSERV;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;  // read+write together counts as a write
          if (!iREN) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != Limit) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
          end
        end else if (iREN) begin
          state_d      = ISERV;
          addr_d       = iaddr;
          store_d      = '0;
          wr_d         = 1'b0;
          starve_cnt_d = '0;
        end
      end
      DSERV: begin
        if (!d_req || ram_ready) begin
          state_d = IDLE;
        end
      end
      ISERV: begin
        if (!iREN || ram_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      store_q      <= '0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      wr_q         <= wr_d;
    end
  end

  // RAM drive and requester responses, all from latched request values.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    if (d_active) begin
      ramWEN   = wr_q;
      ramREN   = ~wr_q;
      ramaddr  = addr_q;
      ramstore = store_q;
      if (ram_ready) begin
        dwait = 1'b0;
        dload = wr_q ? '0 : ramload;
      end
    end else if (i_active) begin
      ramREN   = 1'b1;
      ramaddr  = addr_q;
      ramstore = store_q;
      if (ram_ready) begin
        iwait = 1'b0;
        iload = ramload;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a transaction-level model.
module tb_cache_mem_arbiter;

  localparam int LIMIT = 4;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;

  cache_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ram_ready(ram_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic        iw;
    logic        dw;
    logic [31:0] il;
    logic [31:0] dl;
  } outs_t;

  typedef struct packed {
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        rdy;
    logic [31:0] rload;
    outs_t       exp;
  } vec_t;

  int unsigned n_pass;
  int unsigned n_total;

  vec_t  tbl [13];
  outs_t idle_o;

  // Transaction-level model: who currently holds the RAM and what it asked for.
  int          m_who;    // 0 nobody, 1 data, 2 instruction
  logic [31:0] m_addr;
  logic [31:0] m_store;
  logic        m_write;
  int          m_run;    // data grants in a row while instruction was waiting

  bit          do_rst;
  outs_t       e_rand;
  int          n_grants;
  int          kind;
  int          exp_kind;

  function automatic outs_t mk(input logic ren, input logic wen, input logic [31:0] addr,
                               input logic [31:0] store, input logic iw, input logic dw,
                               input logic [31:0] il, input logic [31:0] dl);
    outs_t o;
    o.ren   = ren;
    o.wen   = wen;
    o.addr  = addr;
    o.store = store;
    o.iw    = iw;
    o.dw    = dw;
    o.il    = il;
    o.dl    = dl;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_outs(input string tag, input outs_t e);
    chk({tag, ".ramREN"},   32'(ramREN),   32'(e.ren));
    chk({tag, ".ramWEN"},   32'(ramWEN),   32'(e.wen));
    chk({tag, ".ramaddr"},  ramaddr,       e.addr);
    chk({tag, ".ramstore"}, ramstore,      e.store);
    chk({tag, ".iwait"},    32'(iwait),    32'(e.iw));
    chk({tag, ".dwait"},    32'(dwait),    32'(e.dw));
    chk({tag, ".iload"},    iload,         e.il);
    chk({tag, ".dload"},    dload,         e.dl);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] ds, input logic rr,
                       input logic [31:0] rl);
    iREN      = ir;
    iaddr     = ia;
    dREN      = dr;
    dWEN      = dw;
    daddr     = da;
    dstore    = ds;
    ram_ready = rr;
    ramload   = rl;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_row(input int k, input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] ds,
                         input logic rr, input logic [31:0] rl, input outs_t e);
    tbl[k].iren   = ir;
    tbl[k].iaddr  = ia;
    tbl[k].dren   = dr;
    tbl[k].dwen   = dw;
    tbl[k].daddr  = da;
    tbl[k].dstore = ds;
    tbl[k].rdy    = rr;
    tbl[k].rload  = rl;
    tbl[k].exp    = e;
  endtask

  task automatic model_reset();
    m_who   = 0;
    m_addr  = '0;
    m_store = '0;
    m_write = 1'b0;
    m_run   = 0;
  endtask

  // Outputs expected this cycle from the transaction in flight.
  function automatic outs_t model_out();
    outs_t e;
    e = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0);
    if (m_who == 1 && (dREN || dWEN)) begin
      e.wen   = m_write;
      e.ren   = !m_write;
      e.addr  = m_addr;
      e.store = m_store;
      if (ram_ready) begin
        e.dw = 1'b0;
        e.dl = m_write ? 32'h0 : ramload;
      end
    end else if (m_who == 2 && iREN) begin
      e.ren  = 1'b1;
      e.addr = m_addr;
      if (ram_ready) begin
        e.iw = 1'b0;
        e.il = ramload;
      end
    end
    return e;
  endfunction

  // Advance the model across one clock edge.
  task automatic model_step();
    bit want_d;
    want_d = dREN || dWEN;
    if (m_who == 1) begin
      if (ram_ready || !want_d) m_who = 0;
    end else if (m_who == 2) begin
      if (ram_ready || !iREN) m_who = 0;
    end else if (want_d && !(iREN && m_run >= LIMIT)) begin
      m_who   = 1;
      m_addr  = daddr;
      m_store = dstore;
      m_write = dWEN;
      m_run   = iREN ? ((m_run + 1 > LIMIT) ? LIMIT : m_run + 1) : 0;
    end else if (iREN) begin
      m_who   = 2;
      m_addr  = iaddr;
      m_store = '0;
      m_write = 1'b0;
      m_run   = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    idle_o  = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0);

    // instruction-only fetches, each followed by an idle bubble
    set_row(0,  1, 32'h40, 0, 0, 32'h0, 32'h0, 1, 32'h2002_0001, idle_o);
    set_row(1,  1, 32'h40, 0, 0, 32'h0, 32'h0, 1, 32'h2002_0001,
            mk(1, 0, 32'h40, 32'h0, 0, 1, 32'h2002_0001, 32'h0));
    set_row(2,  1, 32'h40, 0, 0, 32'h0, 32'h0, 1, 32'h2002_0001, idle_o);
    set_row(3,  1, 32'h40, 0, 0, 32'h0, 32'h0, 1, 32'h2002_0001,
            mk(1, 0, 32'h40, 32'h0, 0, 1, 32'h2002_0001, 32'h0));
    set_row(4,  0, 32'h0,  0, 0, 32'h0, 32'h0, 1, 32'h2002_0001, idle_o);
    // simultaneous requests: data first, bubble, then instruction
    set_row(5,  1, 32'h100, 1, 0, 32'h200, 32'h0, 1, 32'h55, idle_o);
    set_row(6,  1, 32'h100, 1, 0, 32'h200, 32'h0, 1, 32'h55,
            mk(1, 0, 32'h200, 32'h0, 1, 0, 32'h0, 32'h55));
    set_row(7,  1, 32'h100, 0, 0, 32'h200, 32'h0, 1, 32'h55, idle_o);
    set_row(8,  1, 32'h100, 0, 0, 32'h200, 32'h0, 1, 32'h55,
            mk(1, 0, 32'h100, 32'h0, 0, 1, 32'h55, 32'h0));
    set_row(9,  0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 32'h55, idle_o);
    // read and write together behave as a write
    set_row(10, 0, 32'h0, 1, 1, 32'h300, 32'hAAAA_5555, 1, 32'h1234, idle_o);
    set_row(11, 0, 32'h0, 1, 1, 32'h300, 32'hAAAA_5555, 1, 32'h1234,
            mk(0, 1, 32'h300, 32'hAAAA_5555, 1, 0, 32'h0, 32'h0));
    set_row(12, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0, idle_o);

    // reset state
    nRST = 1'b0;
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    chk_outs("reset", idle_o);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    for (int k = 0; k < 13; k++) begin
      drive(tbl[k].iren, tbl[k].iaddr, tbl[k].dren, tbl[k].dwen, tbl[k].daddr, tbl[k].dstore,
            tbl[k].rdy, tbl[k].rload);
      #1;
      chk_outs($sformatf("vec%0d", k), tbl[k].exp);
      tick();
    end

    // wait states; address/data inputs change after the grant and must be ignored
    drive(0, 32'h0, 0, 1, 32'h80, 32'hDEAD_BEEF, 0, 32'h0);
    #1;
    chk_outs("wait.idle", idle_o);
    tick();
    daddr  = 32'hFFF0;
    dstore = 32'h0;
    for (int k = 0; k < 4; k++) begin
      ram_ready = (k == 3);
      #1;
      chk_outs($sformatf("wait.c%0d", k),
               mk(0, 1, 32'h80, 32'hDEAD_BEEF, 1, (k == 3) ? 1'b0 : 1'b1, 32'h0, 32'h0));
      tick();
    end
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    chk_outs("wait.after", idle_o);

    // starvation: instruction gets every fifth grant
    drive(1, 32'h44, 0, 1, 32'h88, 32'h1111_2222, 1, 32'h0);
    n_grants = 0;
    for (int c = 0; c < 40 && n_grants < 11; c++) begin
      #1;
      if (ramWEN || ramREN) begin
        kind     = ramWEN ? 1 : 2;
        exp_kind = (n_grants % (LIMIT + 1) == LIMIT) ? 2 : 1;
        chk($sformatf("starve.grant%0d", n_grants), 32'(kind), 32'(exp_kind));
        if (kind == 2) chk("starve.iaddr", ramaddr, 32'h44);
        n_grants++;
      end
      tick();
    end
    chk("starve.count", 32'(n_grants), 32'd11);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    tick();

    // abort: data requester drops mid-service, even with ram_ready high
    drive(0, 32'h0, 1, 0, 32'h90, 32'h0, 0, 32'h0);
    #1;
    chk_outs("abort.idle", idle_o);
    tick();
    chk_outs("abort.serve", mk(1, 0, 32'h90, 32'h0, 1, 1, 32'h0, 32'h0));
    drive(0, 32'h0, 0, 0, 32'h90, 32'h0, 1, 32'hFFFF_0000);
    #1;
    chk_outs("abort.drop", idle_o);
    tick();
    chk_outs("abort.after", idle_o);

    // reset pulsed during instruction service
    drive(1, 32'h60, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    chk_outs("rst.idle", idle_o);
    tick();
    chk_outs("rst.serve", mk(1, 0, 32'h60, 32'h0, 1, 1, 32'h0, 32'h0));
    ram_ready = 1'b1;
    ramload   = 32'h0000_ABCD;
    nRST      = 1'b0;
    #1;
    chk_outs("rst.async", idle_o);
    tick();
    chk_outs("rst.held", idle_o);
    nRST = 1'b1;
    iREN = 1'b0;
    #1;
    chk_outs("rst.release", idle_o);

    // randomized traffic against the model
    model_reset();
    for (int c = 0; c < 400; c++) begin
      do_rst = ($urandom_range(0, 49) == 0);
      drive(($urandom_range(0, 9) < 7), $urandom(), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 9) < 3), $urandom(), $urandom(), ($urandom_range(0, 1) == 1),
            $urandom());
      if (do_rst) begin
        nRST = 1'b0;
        model_reset();
      end
      #1;
      e_rand = model_out();
      chk_outs($sformatf("rand%0d", c), e_rand);
      chk($sformatf("rand%0d.strobe_excl", c), 32'(ramREN & ramWEN), 32'h0);
      @(posedge CLK);
      if (!do_rst) model_step();
      #1;
      nRST = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the number of consecutive data grants allowed while an instruction request is pending.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 iREN  input  1  instruction-side read request.
REQ-005 iaddr  input  32  instruction read address.
REQ-006 iwait  output  1  instruction access not complete; low for exactly one cycle when iload is valid.
REQ-007 iload  output  32  instruction read data.
REQ-008 dREN  input  1  data-side read request.
REQ-009 dWEN  input  1  data-side write request.
REQ-010 daddr  input  32  data address.
REQ-011 dstore  input  32  data write value.
REQ-012 dwait  output  1  data access not complete; low for exactly one cycle on completion.
REQ-013 dload  output  32  data read value.
REQ-014 ramREN  output  1  RAM read strobe.
REQ-015 ramWEN  output  1  RAM write strobe.
REQ-016 ramaddr  output  32  RAM address.
REQ-017 ramstore  output  32  RAM write data.
REQ-018 ramload  input  32  RAM read data, valid when ram_ready high.
REQ-019 ram_ready  input  1  RAM completes the current access this cycle.

Function
REQ-020 FSM states SHALL be IDLE, DSERV and ISERV; exactly one active.
REQ-021 IDLE with no request (iREN=dREN=dWEN=0) SHALL stay in IDLE.
REQ-022 IDLE arbitration: data request wins over instruction request unless starve_cnt equals STARVE_LIMIT and iREN=1, in which case ISERV is chosen.
REQ-023 On the arbitration edge the winner's address (and dstore, and write/read kind) SHALL be latched into internal registers; RAM outputs are driven only from latched values.
REQ-024 In DSERV: ramWEN=1 if latched kind is write, else ramREN=1; ramaddr=latched daddr; ramstore=latched dstore.
REQ-025 In ISERV: ramREN=1, ramWEN=0, ramaddr=latched iaddr, ramstore=0.
REQ-026 dREN and dWEN both high SHALL be treated as a write.
REQ-027 iwait and dwait SHALL default to 1; in ISERV (DSERV) with ram_ready=1, iwait (dwait) SHALL be 0 that cycle, combinationally.
REQ-028 iload (dload) SHALL equal ramload in ISERV (DSERV) when ram_ready=1, else 0; dload is 0 for writes.
REQ-029 Completion (ram_ready=1 in a serve state) SHALL return FSM to IDLE next edge; minimum latency request-to-completion is 1 cycle after the request cycle, followed by one IDLE bubble.
REQ-030 ram_ready=0 in a serve state SHALL hold state and all RAM outputs unchanged.
REQ-031 Requester deasserting its request mid-service SHALL abort: RAM strobes low that cycle, FSM to IDLE next edge, no wait-low pulse.
REQ-032 starve_cnt (width ceil(log2(STARVE_LIMIT+1))) SHALL increment on each DSERV grant with iREN=1, saturate at STARVE_LIMIT, clear on any ISERV grant and on a DSERV grant with iREN=0.
REQ-033 ram_ready while IDLE SHALL be ignored; ramREN and ramWEN SHALL never both be 1.

Reset
REQ-034 nRST low SHALL immediately force state IDLE, starve_cnt 0, latched address/data/kind 0.
REQ-035 During and after reset until the next grant: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, iload=0, dload=0.
REQ-036 Reset asserted mid-service SHALL drop RAM strobes in the same cycle with no completion pulse.

Verification
REQ-037 Instruction only: iREN=1, iaddr=0x0000_0040, ram_ready=1 always, ramload=0x2002_0001 -> next cycle ISERV, ramaddr=0x40, iwait=0, iload=0x2002_0001; then one IDLE cycle.
REQ-038 Simultaneous: iREN=1 iaddr=0x100, dREN=1 daddr=0x200, ram_ready=1 -> DSERV first (ramaddr=0x200, dwait pulse), bubble, then ISERV (ramaddr=0x100, iwait pulse).
REQ-039 Starvation: iREN held 1, dWEN held 1, STARVE_LIMIT=4 -> exactly 4 data writes, 5th grant is ISERV, starve_cnt returns 0.
REQ-040 Wait states: dWEN=1 daddr=0x80 dstore=0xDEAD_BEEF, ram_ready low 3 cycles then high -> ramWEN=1, ramaddr/ramstore stable 4 cycles, dwait low only on 4th.
REQ-041 Abort and reset: dREN dropped during DSERV with ram_ready=0 -> strobes low, IDLE, dwait stays 1; nRST pulsed during ISERV -> outputs per REQ-035 immediately.
REQ-042 Both dREN=dWEN=1 with ram_ready=1 -> ramWEN=1, ramREN=0, dload=0.
